instr_fetch: RTL and testbench

//  Instruction fetch/sequencer feeding the 9-bit control_logic decoder. Owns the program counter,

---
 rtl/instr_fetch_if.sv | 24 ++
 rtl/instr_fetch.sv | 112 +++++++++++
 tb/tb_instr_fetch.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Decoder-facing instruction interface: fetch unit presents instructions,
// datapath returns stall, redirect and completion.
interface instr_fetch_if #(
  parameter int unsigned PC_W = 10
);
  logic [8:0]      instr;
  logic            instr_valid;
  logic [PC_W-1:0] exec_pc;
  logic            stall_i;
  logic            br_take;
  logic            br_rel;
  logic [PC_W-1:0] br_target;
  logic            done_i;

  modport master (
    output instr, instr_valid, exec_pc,
    input  stall_i, br_take, br_rel, br_target, done_i
  );

  modport slave (
    input  instr, instr_valid, exec_pc,
    output stall_i, br_take, br_rel, br_target, done_i
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch/sequencer: owns the PC, reads a synchronous ROM and
// presents one instruction per cycle, redirecting on branch and halting on done.
module instr_fetch #(
  parameter int unsigned     PC_W      = 10,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [8:0]      NOP_INSTR = 9'h066
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      imem_rdata,
  output logic            busy,
  output logic            halted,
  instr_fetch_if.master   dec
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, HALT} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] exec_pc_q, exec_pc_d;
  logic            valid_q, valid_d;
  logic            hold_vld_q, hold_vld_d;
  logic [8:0]      hold_q, hold_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;
  logic [PC_W-1:0] br_dest;

  assign br_dest = dec.br_rel ? (exec_pc_q + dec.br_target) : dec.br_target;

  // The post-branch squash bubble reuses FILL: both are the single
  // ROM-latency cycle with instr_valid low before the target arrives.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    exec_pc_d  = exec_pc_q;
    valid_d    = valid_q;
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    unique case (state_q)
      IDLE, HALT: begin
        valid_d = 1'b0;
        if (start) begin
          fetch_pc_d = RESET_PC;
          state_d    = FILL;
        end
      end
      FILL: begin
        fetch_pc_d = fetch_pc_q + PC_W'(1);
        exec_pc_d  = fetch_pc_q;
        valid_d    = 1'b1;
        hold_vld_d = 1'b0;
        state_d    = RUN;
      end
      RUN: begin
        if (dec.stall_i) begin
          // ROM address is frozen but rdata moves on; capture the shown word once.
          hold_vld_d = 1'b1;
          if (!hold_vld_q) hold_d = imem_rdata;
        end else begin
          hold_vld_d = 1'b0;
          if (dec.done_i) begin
            valid_d = 1'b0;
            state_d = HALT;
          end else if (dec.br_take) begin
            fetch_pc_d = br_dest;
            valid_d    = 1'b0;
            state_d    = FILL;
          end else begin
            exec_pc_d  = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d   = (state_d == FILL) || (state_d == RUN);
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      exec_pc_q  <= '0;
      valid_q    <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      exec_pc_q  <= exec_pc_d;
      valid_q    <= valid_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_addr       = fetch_pc_q;
  assign dec.exec_pc     = exec_pc_q;
  assign dec.instr_valid = valid_q;
  assign dec.instr       = !valid_q   ? NOP_INSTR :
                           hold_vld_q ? hold_q    : imem_rdata;
  assign busy            = busy_q;
  assign halted          = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic, checked
// against a pending-target reference model and a behavioural ROM.
module tb_instr_fetch;
  localparam int unsigned PC_W = 10;
  localparam logic [8:0]  NOP  = 9'h066;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [PC_W-1:0] imem_addr;
  logic [8:0]      imem_rdata;
  logic            busy, halted;

  instr_fetch_if #(.PC_W(PC_W)) dec ();

  instr_fetch #(.PC_W(PC_W), .RESET_PC('0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .busy(busy), .halted(halted), .dec(dec)
  );

  always #5 clk = ~clk;

  logic [8:0] rom [0:(1<<PC_W)-1];
  always_ff @(posedge clk) imem_rdata <= rom[imem_addr];

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference: running flag, presenting flag, executing PC, and the PC
  // to present once the pending bubble clears.
  bit              m_run, m_halt, m_valid;
  logic [PC_W-1:0] m_pc, m_next;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_halt = 0; m_valid = 0; m_pc = '0; m_next = '0;
  endtask

  task automatic model_edge();
    if (!m_run) begin
      if (start) begin m_run = 1; m_halt = 0; m_valid = 0; m_next = '0; end
    end else if (!m_valid) begin
      m_valid = 1; m_pc = m_next;
    end else if (dec.stall_i) begin
      m_valid = 1;
    end else if (dec.done_i) begin
      m_run = 0; m_halt = 1; m_valid = 0;
    end else if (dec.br_take) begin
      m_valid = 0;
      m_next  = dec.br_rel ? PC_W'(m_pc + dec.br_target) : dec.br_target;
    end else begin
      m_pc = m_pc + PC_W'(1);
    end
  endtask

  task automatic check_outputs();
    check("valid",  32'(dec.instr_valid), 32'(m_valid));
    check("instr",  32'(dec.instr), m_valid ? 32'(rom[m_pc]) : 32'(NOP));
    check("busy",   32'(busy),   32'(m_run));
    check("halted", 32'(halted), 32'(m_halt));
    if (m_valid) check("exec_pc", 32'(dec.exec_pc), 32'(m_pc));
    if (m_run)   check("imem_addr", 32'(imem_addr), m_valid ? 32'(PC_W'(m_pc + 1)) : 32'(m_next));
  endtask

  task automatic idle_in();
    start = 0; dec.stall_i = 0; dec.br_take = 0; dec.br_rel = 0;
    dec.br_target = '0; dec.done_i = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run_to(input logic [PC_W-1:0] pc, input int unsigned lim);
    for (int unsigned i = 0; i < lim; i++) begin
      if (m_valid && m_pc == pc) break;
      step();
    end
    check("reach_pc", 32'(dec.exec_pc), 32'(pc));
  endtask

  task automatic check_reset_vals();
    check("rst_valid",  32'(dec.instr_valid), 32'd0);
    check("rst_instr",  32'(dec.instr), 32'(NOP));
    check("rst_exec",   32'(dec.exec_pc), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_addr",   32'(imem_addr), 32'd0);
  endtask

  initial begin
    for (int unsigned i = 0; i < (1 << PC_W); i++) rom[i] = 9'(i);
    idle_in();
    model_reset();
    #12;
    check_reset_vals();
    rst_n = 1;
    step(); step();

    // sequential run from start: valid two edges after start is sampled
    start = 1; step(); start = 0;
    check("fill_bubble", 32'(dec.instr_valid), 32'd0);
    step();
    check("first_pc", 32'(dec.exec_pc), 32'd0);
    for (int i = 0; i < 3; i++) step();
    start = 1; step(); start = 0;      // start while busy is ignored

    // absolute branch 0x005 -> 0x040
    run_to(10'h005, 20);
    dec.br_take = 1; dec.br_target = 10'h040; step(); idle_in();
    check("br_bubble", 32'(dec.instr), 32'(NOP));
    dec.br_take = 1; dec.br_target = 10'h123; step(); idle_in(); // ignored in bubble
    check("br_abs_pc", 32'(dec.exec_pc), 32'h040);

    // relative -2 from 0x001 -> 0x3FF then wrap
    dec.br_take = 1; dec.br_target = 10'h001; step(); idle_in(); step();
    dec.br_take = 1; dec.br_rel = 1; dec.br_target = 10'h3FE; step(); idle_in(); step();
    check("br_rel_pc", 32'(dec.exec_pc), 32'h3FF);
    step();
    check("wrap_pc", 32'(dec.exec_pc), 32'h000);

    // three-cycle stall at 0x010
    run_to(10'h010, 40);
    dec.stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      dec.br_take = (i == 1); dec.br_target = 10'h200; dec.done_i = (i == 2);
      step();
      check("stall_pc", 32'(dec.exec_pc), 32'h010);
    end
    idle_in();
    check("stall_instr", 32'(dec.instr), 32'(rom[10'h010]));
    step();
    check("post_stall_pc", 32'(dec.exec_pc), 32'h011);

    // done beats simultaneous br_take; start with done is dropped
    step();
    dec.done_i = 1; dec.br_take = 1; dec.br_target = 10'h100; start = 1; step(); idle_in();
    check("halt_flag", 32'(halted), 32'd1);
    step(); step();
    start = 1; step(); start = 0; step();
    check("restart_pc", 32'(dec.exec_pc), 32'd0);
    for (int i = 0; i < 5; i++) step();

    // asynchronous reset mid-run
    #3 rst_n = 0;
    #1 check_reset_vals();
    model_reset();
    #10 rst_n = 1;
    step();
    start = 1; step(); start = 0; step();
    check("post_rst_pc", 32'(dec.exec_pc), 32'd0);

    // random traffic over a random program
    dec.done_i = 1; step(); idle_in();
    for (int unsigned i = 0; i < (1 << PC_W); i++) rom[i] = 9'($urandom);
    for (int i = 0; i < 3000; i++) begin
      start         = ($urandom_range(0, 9) == 0);
      dec.stall_i   = ($urandom_range(0, 4) == 0);
      dec.br_take   = ($urandom_range(0, 7) == 0);
      dec.br_rel    = 1'($urandom);
      dec.br_target = PC_W'($urandom);
      dec.done_i    = ($urandom_range(0, 39) == 0);
      step();
    end
    idle_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
